// File: rtl/regfile_port_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_port_ctrl_if                                            |
// | Brief    : Decode/WB request and regfile port bundle for regfile_port_ctrl |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface regfile_port_ctrl_if #(
  parameter int WB_DEPTH = 4,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
);
  localparam int CNT_W = $clog2(WB_DEPTH) + 1;

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              rd_resp_valid;
  logic              rd_resp_ready;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rf_rw;
  logic [ADDR_W-1:0] rf_raddr1;
  logic [ADDR_W-1:0] rf_raddr2;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_out1;
  logic [DATA_W-1:0] rf_out2;
  logic [CNT_W-1:0]  wb_pending;

  modport master (
    output wb_valid, wb_addr, wb_data,
    output rd_req_valid, rd_addr1, rd_addr2, rd_resp_ready,
    output rf_out1, rf_out2,
    input  wb_ready, rd_req_ready, rd_resp_valid, rd_data1, rd_data2,
    input  rf_rw, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, wb_pending
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  rd_req_valid, rd_addr1, rd_addr2, rd_resp_ready,
    input  rf_out1, rf_out2,
    output wb_ready, rd_req_ready, rd_resp_valid, rd_data1, rd_data2,
    output rf_rw, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, wb_pending
  );
endinterface
`default_nettype wire

// File: rtl/regfile_port_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_port_ctrl                                               |
// | Brief    : Serialises buffered writebacks and operand reads on the single  |
// |            regfile port, forwarding not-yet-written data to reads.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module regfile_port_ctrl #(
  parameter int WB_DEPTH = 4,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  wire logic          clk,
  input  wire logic          rst,
  regfile_port_ctrl_if.slave io_bus
);
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [ADDR_W-1:0]  r_fifo_addr [WB_DEPTH];
  logic [DATA_W-1:0]  r_fifo_data [WB_DEPTH];
  logic [CNT_W-1:0]   r_wptr;
  logic [CNT_W-1:0]   r_rptr;

  logic               r_rf_rw;
  logic [ADDR_W-1:0]  r_rf_raddr1;
  logic [ADDR_W-1:0]  r_rf_raddr2;
  logic [ADDR_W-1:0]  r_rf_waddr;
  logic [DATA_W-1:0]  r_rf_wdata;
  logic [DATA_W-1:0]  r_rd_data1;
  logic [DATA_W-1:0]  r_rd_data2;

  logic [CNT_W-1:0]   w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_enq;
  logic               w_store;
  logic               w_deq;
  logic               w_rd_accept;
  logic [PTR_W-1:0]   w_head;
  logic               w_hit1;
  logic               w_hit2;
  logic [DATA_W-1:0]  w_fwd1;
  logic [DATA_W-1:0]  w_fwd2;
  logic [DATA_W-1:0]  w_rd_val1;
  logic [DATA_W-1:0]  w_rd_val2;

  assign w_count = r_wptr - r_rptr;
  assign w_full  = (w_count == CNT_W'(WB_DEPTH));
  assign w_empty = (w_count == '0);
  assign w_head  = r_rptr[PTR_W-1:0];
  assign w_enq   = io_bus.wb_valid && !w_full;
  // Writes to r0 complete the handshake but are dropped.
  assign w_store = w_enq && (io_bus.wb_addr != '0) && !rst;
  assign w_deq   = (r_state == ST_WRITE);

  always_comb begin
    w_next_state = r_state;
    w_rd_accept  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_full) begin
          w_next_state = ST_WRITE;
        end else if (io_bus.rd_req_valid) begin
          w_next_state = ST_READ;
          w_rd_accept  = 1'b1;
        end else if (!w_empty) begin
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: w_next_state = ST_IDLE;
      ST_READ:  w_next_state = ST_RESP;
      ST_RESP:  if (io_bus.rd_resp_ready) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_fwd1 = '0;
    w_fwd2 = '0;
    v_idx  = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      v_idx = w_head + PTR_W'(i);
      if (CNT_W'(i) < w_count) begin
        if (r_fifo_addr[v_idx] == r_rf_raddr1) begin
          w_hit1 = 1'b1;
          w_fwd1 = r_fifo_data[v_idx];
        end
        if (r_fifo_addr[v_idx] == r_rf_raddr2) begin
          w_hit2 = 1'b1;
          w_fwd2 = r_fifo_data[v_idx];
        end
      end
    end
  end

  assign w_rd_val1 = (r_rf_raddr1 == '0) ? '0 : (w_hit1 ? w_fwd1 : io_bus.rf_out1);
  assign w_rd_val2 = (r_rf_raddr2 == '0) ? '0 : (w_hit2 ? w_fwd2 : io_bus.rf_out2);

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_fifo_addr[r_wptr[PTR_W-1:0]] <= io_bus.wb_addr;
      r_fifo_data[r_wptr[PTR_W-1:0]] <= io_bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_rf_rw     <= 1'b1;
      r_rf_raddr1 <= '0;
      r_rf_raddr2 <= '0;
      r_rf_waddr  <= '0;
      r_rf_wdata  <= '0;
      r_rd_data1  <= '0;
      r_rd_data2  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_store) r_wptr <= r_wptr + 1'b1;
      if (w_deq)   r_rptr <= r_rptr + 1'b1;
      if (w_rd_accept) begin
        r_rf_raddr1 <= io_bus.rd_addr1;
        r_rf_raddr2 <= io_bus.rd_addr2;
      end
      if (r_state == ST_READ) begin
        r_rd_data1 <= w_rd_val1;
        r_rd_data2 <= w_rd_val2;
      end
      // Port outputs are registered from the next state so WRITE sees them for its whole cycle.
      if (w_next_state == ST_WRITE) begin
        r_rf_rw    <= 1'b0;
        r_rf_waddr <= r_fifo_addr[w_head];
        r_rf_wdata <= r_fifo_data[w_head];
      end else begin
        r_rf_rw    <= 1'b1;
        r_rf_waddr <= '0;
        r_rf_wdata <= '0;
      end
    end
  end

  assign io_bus.wb_ready      = !w_full;
  assign io_bus.rd_req_ready  = (r_state == ST_IDLE) && !w_full;
  assign io_bus.rd_resp_valid = (r_state == ST_RESP);
  assign io_bus.rd_data1      = r_rd_data1;
  assign io_bus.rd_data2      = r_rd_data2;
  assign io_bus.rf_rw         = r_rf_rw;
  assign io_bus.rf_raddr1     = r_rf_raddr1;
  assign io_bus.rf_raddr2     = r_rf_raddr2;
  assign io_bus.rf_waddr      = r_rf_waddr;
  assign io_bus.rf_wdata      = r_rf_wdata;
  assign io_bus.wb_pending    = w_count;
endmodule
`default_nettype wire

// File: tb/tb_regfile_port_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_regfile_port_ctrl                                            |
// | Brief    : Directed + random bench with a queue-based write/read model     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_regfile_port_ctrl;
  localparam int WB_DEPTH = 4;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_port_ctrl_if #(.WB_DEPTH(WB_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_port_ctrl #(.WB_DEPTH(WB_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  typedef struct { logic [4:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] d1; logic [31:0] d2; int cyc; } rd_t;

  wr_t         pend [$];
  rd_t         exp_q [$];
  bit          resp_seen = 1'b0;
  bit          mon_en = 1'b0;
  logic [31:0] mem_ref [32];
  logic [31:0] regmem [32];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_wr = 0;
  int          cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] seed(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  // Architectural value: regfile contents overlaid by all writes still waiting, in order.
  function automatic logic [31:0] ref_read(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0) return 32'd0;
    v = mem_ref[a];
    foreach (pend[i]) if (pend[i].addr == a) v = pend[i].data;
    return v;
  endfunction

  assign bus.rf_out1 = regmem[bus.rf_raddr1];
  assign bus.rf_out2 = regmem[bus.rf_raddr2];

  always @(posedge clk) begin
    if (!mon_en) begin
      for (int i = 0; i < 32; i++) regmem[i] <= seed(i);
    end else if (bus.rf_rw == 1'b0) begin
      regmem[bus.rf_waddr] <= bus.rf_wdata;
    end
  end

  always @(negedge clk) begin
    if (!mon_en) begin
      for (int i = 0; i < 32; i++) mem_ref[i] = seed(i);
    end else begin
      check_val("pending", 32'(bus.wb_pending), 32'(pend.size()));
      check_val("wb_ready", 32'(bus.wb_ready), 32'(pend.size() < WB_DEPTH));
      if (pend.size() == WB_DEPTH || exp_q.size() != 0)
        check_val("rd_req_blocked", 32'(bus.rd_req_ready), 32'd0);
      if (bus.rf_rw) begin
        check_val("waddr_idle", 32'(bus.rf_waddr), 32'd0);
      end else begin
        n_wr++;
        check_val("wr_outstanding", 32'(pend.size() != 0), 32'd1);
        if (pend.size() != 0) begin
          check_val("rf_waddr", 32'(bus.rf_waddr), 32'(pend[0].addr));
          check_val("rf_wdata", bus.rf_wdata, pend[0].data);
          mem_ref[pend[0].addr] = pend[0].data;
          void'(pend.pop_front());
        end
      end
      if (bus.rd_resp_valid) begin
        check_val("resp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          if (!resp_seen) begin
            check_val("rd_latency", 32'(cyc - exp_q[0].cyc), 32'd2);
            resp_seen = 1'b1;
          end
          if (bus.rd_resp_ready) begin
            check_val("rd_data1", bus.rd_data1, exp_q[0].d1);
            check_val("rd_data2", bus.rd_data2, exp_q[0].d2);
            void'(exp_q.pop_front());
            resp_seen = 1'b0;
          end
        end
      end
      if (rst) begin
        pend.delete();
        exp_q.delete();
        resp_seen = 1'b0;
      end else begin
        if (bus.wb_valid && bus.wb_ready && bus.wb_addr != 5'd0)
          pend.push_back('{addr: bus.wb_addr, data: bus.wb_data});
        if (bus.rd_req_valid && bus.rd_req_ready)
          exp_q.push_back('{d1: ref_read(bus.rd_addr1), d2: ref_read(bus.rd_addr2), cyc: cyc});
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.wb_valid      = 1'b0;
    bus.rd_req_valid  = 1'b0;
    bus.rd_resp_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = a;
    bus.wb_data  = d;
    tick();
    bus.wb_valid = 1'b0;
  endtask

  task automatic rd_issue(input logic [4:0] a1, input logic [4:0] a2);
    int k = 0;
    bus.rd_req_valid = 1'b1;
    bus.rd_addr1     = a1;
    bus.rd_addr2     = a2;
    while (!bus.rd_req_ready && k < 50) begin
      tick();
      k++;
    end
    check_val("rd_accept_timeout", 32'(bus.rd_req_ready), 32'd1);
    tick();
    bus.rd_req_valid = 1'b0;
  endtask

  task automatic rd_wait(output logic [31:0] d1);
    int k = 0;
    while (!bus.rd_resp_valid && k < 50) begin
      tick();
      k++;
    end
    check_val("resp_timeout", 32'(bus.rd_resp_valid), 32'd1);
    d1 = bus.rd_data1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          base;
    bus.wb_valid      = 1'b0;
    bus.wb_addr       = '0;
    bus.wb_data       = '0;
    bus.rd_req_valid  = 1'b0;
    bus.rd_addr1      = '0;
    bus.rd_addr2      = '0;
    bus.rd_resp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    check_val("rst_rf_rw", 32'(bus.rf_rw), 32'd1);
    check_val("rst_wb_ready", 32'(bus.wb_ready), 32'd1);
    check_val("rst_pending", 32'(bus.wb_pending), 32'd0);
    check_val("rst_resp_valid", 32'(bus.rd_resp_valid), 32'd0);
    check_val("rst_rd_data1", bus.rd_data1, 32'd0);
    check_val("rst_rf_wdata", bus.rf_wdata, 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Simple write then read-back through the regfile.
    base = n_wr;
    wb(5'd3, 32'hDEAD_BEEF);
    idle(4);
    check_val("t2_one_write", 32'(n_wr - base), 32'd1);
    check_val("t2_regmem", regmem[3], 32'hDEAD_BEEF);
    rd_issue(5'd3, 5'd0);
    rd_wait(d);
    check_val("t2_rd", d, 32'hDEAD_BEEF);
    idle(3);

    // Two writes to one register buffered behind a held response; read must forward the last.
    bus.rd_resp_ready = 1'b0;
    rd_issue(5'd1, 5'd2);
    rd_wait(d);
    wb(5'd5, 32'd1);
    wb(5'd5, 32'd2);
    check_val("t3_pending", 32'(bus.wb_pending), 32'd2);
    bus.rd_resp_ready = 1'b1;
    rd_issue(5'd5, 5'd0);
    rd_wait(d);
    check_val("t3_fwd", d, 32'd2);
    idle(8);
    check_val("t3_drained", regmem[5], 32'd2);

    // Fill the FIFO; the read waits for one drain.
    bus.rd_resp_ready = 1'b0;
    rd_issue(5'd4, 5'd0);
    rd_wait(d);
    for (int i = 0; i < 4; i++) wb(5'(8 + i), 32'h100 + 32'(i));
    check_val("t4_full_ready", 32'(bus.wb_ready), 32'd0);
    check_val("t4_full_pending", 32'(bus.wb_pending), 32'd4);
    bus.rd_resp_ready = 1'b1;
    rd_issue(5'd8, 5'd11);
    rd_wait(d);
    check_val("t4_rd", d, 32'h100);
    idle(8);

    // r0 writes are dropped, r0 reads return zero.
    base = n_wr;
    wb(5'd0, 32'h1234);
    check_val("t5_pending", 32'(bus.wb_pending), 32'd0);
    rd_issue(5'd0, 5'd0);
    rd_wait(d);
    check_val("t5_rd", d, 32'd0);
    idle(3);
    check_val("t5_no_write", 32'(n_wr - base), 32'd0);

    // Reset in the middle of a drain discards what is still buffered.
    bus.rd_resp_ready = 1'b0;
    rd_issue(5'd1, 5'd1);
    rd_wait(d);
    wb(5'd12, 32'hC0DE_000C);
    wb(5'd13, 32'hC0DE_000D);
    wb(5'd14, 32'hC0DE_000E);
    bus.rd_resp_ready = 1'b1;
    tick();
    tick();
    check_val("t6_in_write", 32'(bus.rf_rw), 32'd0);
    check_val("t6_write_addr", 32'(bus.rf_waddr), 32'd12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t6_pending", 32'(bus.wb_pending), 32'd0);
    check_val("t6_rf_rw", 32'(bus.rf_rw), 32'd1);
    check_val("t6_resp_valid", 32'(bus.rd_resp_valid), 32'd0);
    idle(6);
    check_val("t6_r13_untouched", regmem[13], seed(13));
    check_val("t6_r14_untouched", regmem[14], seed(14));

    // Random traffic on a small register window to provoke forwarding hits.
    for (int c = 0; c < 3000; c++) begin
      rst               = ($urandom_range(0, 299) == 0);
      bus.wb_valid      = ($urandom_range(0, 2) == 0);
      bus.wb_addr       = 5'($urandom_range(0, 7));
      bus.wb_data       = $urandom;
      bus.rd_req_valid  = ($urandom_range(0, 3) == 0);
      bus.rd_addr1      = 5'($urandom_range(0, 7));
      bus.rd_addr2      = 5'($urandom_range(0, 7));
      bus.rd_resp_ready = ($urandom_range(0, 1) == 0);
      tick();
    end
    rst = 1'b0;
    idle(20);
    check_val("final_pending", 32'(bus.wb_pending), 32'd0);
    for (int i = 0; i < 32; i++) check_val("final_regfile", regmem[i], mem_ref[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
